// File: rtl/bpred_pkg.sv
// Shared definitions for the branch target buffer.
//   - Default parameter values for the BTB and its counter.
//   - FSM state encoding (IDLE / SWEEP).
//   - Entry layout at the default widths: valid, tag, target, counter.
package bpred_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int IDX_W_DEF = 8;
  localparam int TAG_W_DEF = 4;
  localparam int CTR_W_DEF = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } btb_state_e;

  typedef struct packed {
    logic                 valid;
    logic [TAG_W_DEF-1:0] tag;
    logic [XLEN_DEF-1:0]  target;
    logic [CTR_W_DEF-1:0] ctr;
  } btb_entry_t;

endpackage

// File: rtl/bpred_btb_sat_ctr.sv
// Saturating up/down counter step used on the BTB update path.
//   ctr_i   : current counter value
//   taken_i : resolved direction (1 = count up, 0 = count down)
//   ctr_o   : next counter value, clamped to [0, 2**CTR_W-1]
module sat_ctr import bpred_pkg::*; #(
  parameter int CTR_W = CTR_W_DEF
) (
  input  logic [CTR_W-1:0] ctr_i,
  input  logic             taken_i,
  output logic [CTR_W-1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (taken_i) begin
      if (ctr_i != {CTR_W{1'b1}}) begin
        ctr_o = ctr_i + 1'b1;
      end
    end else begin
      if (ctr_i != {CTR_W{1'b0}}) begin
        ctr_o = ctr_i - 1'b1;
      end
    end
  end

endmodule

// File: rtl/bpred_btb.sv
// Direct-mapped branch target buffer with per-entry saturating direction
// counters and a one-entry-per-cycle invalidation sweep.
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   lkp_pc_i        : IF-stage PC; lkp_hit_o / lkp_taken_o / lkp_target_o
//                     are combinational from the current table contents
//   upd_valid_i ... : resolved branch from EX, written on the sampling edge
//   flush_i         : pulse that starts a full-table invalidation sweep
//   busy_o          : sweep in progress (lookups miss, updates dropped)
// Requires XLEN >= IDX_W + TAG_W + 2 and CTR_W >= 2.
module bpred_btb import bpred_pkg::*; #(
  parameter int XLEN  = XLEN_DEF,
  parameter int IDX_W = IDX_W_DEF,
  parameter int TAG_W = TAG_W_DEF,
  parameter int CTR_W = CTR_W_DEF
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [XLEN-1:0] lkp_pc_i,
  output logic            lkp_hit_o,
  output logic            lkp_taken_o,
  output logic [XLEN-1:0] lkp_target_o,
  input  logic            upd_valid_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic            upd_taken_i,
  input  logic [XLEN-1:0] upd_target_i,
  input  logic            flush_i,
  output logic            busy_o
);

  localparam int N = 1 << IDX_W;
  // A freshly allocated entry starts weakly taken.
  localparam logic [CTR_W-1:0] CTR_WEAK = {1'b1, {(CTR_W-1){1'b0}}};

  btb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  logic             valid_q  [N];
  logic             valid_d  [N];
  logic [CTR_W-1:0] ctr_q    [N];
  logic [CTR_W-1:0] ctr_d    [N];
  logic [TAG_W-1:0] tag_q    [N];
  logic [TAG_W-1:0] tag_d    [N];
  logic [XLEN-1:0]  target_q [N];
  logic [XLEN-1:0]  target_d [N];

  logic [IDX_W-1:0] lkp_idx, upd_idx;
  logic [TAG_W-1:0] lkp_tag, upd_tag;
  logic             lkp_match, upd_hit;
  logic [CTR_W-1:0] ctr_nxt;
  logic             unused_pc;

  assign lkp_idx = lkp_pc_i[IDX_W+1:2];
  assign lkp_tag = lkp_pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_idx = upd_pc_i[IDX_W+1:2];
  assign upd_tag = upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];

  // Byte-offset bits and PC bits above the tag never take part in matching.
  assign unused_pc = ^{lkp_pc_i, upd_pc_i};

  // Lookup reads the registered table only, so a same-cycle update to the
  // same index is seen one cycle later.
  assign lkp_match    = valid_q[lkp_idx] && (tag_q[lkp_idx] == lkp_tag);
  assign lkp_hit_o    = lkp_match && (state_q == IDLE);
  assign lkp_taken_o  = lkp_hit_o && ctr_q[lkp_idx][CTR_W-1];
  assign lkp_target_o = lkp_hit_o ? target_q[lkp_idx] : {XLEN{1'b0}};
  assign busy_o       = (state_q == SWEEP);

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  sat_ctr #(
    .CTR_W (CTR_W)
  ) u_sat_ctr (
    .ctr_i   (ctr_q[upd_idx]),
    .taken_i (upd_taken_i),
    .ctr_o   (ctr_nxt)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    valid_d  = valid_q;
    ctr_d    = ctr_q;
    tag_d    = tag_q;
    target_d = target_q;
    unique case (state_q)
      IDLE: begin
        // Flush takes priority: a coincident update is dropped.
        if (flush_i) begin
          state_d = SWEEP;
          ptr_d   = {IDX_W{1'b0}};
        end else if (upd_valid_i) begin
          if (upd_hit) begin
            ctr_d[upd_idx] = ctr_nxt;
            if (upd_taken_i) begin
              target_d[upd_idx] = upd_target_i;
            end
          end else if (upd_taken_i) begin
            // Taken miss replaces whatever aliased into this slot.
            valid_d[upd_idx]  = 1'b1;
            tag_d[upd_idx]    = upd_tag;
            target_d[upd_idx] = upd_target_i;
            ctr_d[upd_idx]    = CTR_WEAK;
          end
        end
      end
      SWEEP: begin
        // Flush requests are ignored here; the sweep always runs to the end.
        valid_d[ptr_q] = 1'b0;
        ptr_d          = ptr_q + 1'b1;
        if (ptr_q == {IDX_W{1'b1}}) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= {IDX_W{1'b0}};
      for (int i = 0; i < N; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= {CTR_W{1'b0}};
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      ctr_q   <= ctr_d;
    end
  end

  // Tag and target are qualified by valid, so they carry no reset.
  always_ff @(posedge clk_i) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

endmodule

// File: tb/tb_bpred_btb.sv
// Self-checking bench for bpred_btb at default parameters.
module tb_bpred_btb;
  import bpred_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] lkp_pc;
  logic        lkp_hit;
  logic        lkp_taken;
  logic [31:0] lkp_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        flush;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  // Reference model: table of entries plus sweep progress.
  btb_entry_t mdl [256];
  bit         m_busy;
  int         m_sweep_cnt;

  bpred_btb dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .lkp_pc_i     (lkp_pc),
    .lkp_hit_o    (lkp_hit),
    .lkp_taken_o  (lkp_taken),
    .lkp_target_o (lkp_target),
    .upd_valid_i  (upd_valid),
    .upd_pc_i     (upd_pc),
    .upd_taken_i  (upd_taken),
    .upd_target_i (upd_target),
    .flush_i      (flush),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) mdl[i] = '0;
    m_busy      = 1'b0;
    m_sweep_cnt = 0;
  endtask

  // Compare current DUT outputs with the model's view for lookup PC pc.
  task automatic check_lookup(input string tag, input logic [31:0] pc);
    int         idx;
    logic [3:0] tg;
    bit         eh;
    bit         et;
    logic [31:0] etgt;
    idx  = int'((pc >> 2) & 32'hFF);
    tg   = 4'((pc >> 10) & 32'hF);
    eh   = !m_busy && mdl[idx].valid && (mdl[idx].tag == tg);
    et   = eh && (mdl[idx].ctr >= 2);
    etgt = eh ? mdl[idx].target : 32'h0;
    chk({tag, ".hit"},    {31'b0, lkp_hit},   {31'b0, eh});
    chk({tag, ".taken"},  {31'b0, lkp_taken}, {31'b0, et});
    chk({tag, ".target"}, lkp_target,         etgt);
    chk({tag, ".busy"},   {31'b0, busy},      {31'b0, m_busy});
  endtask

  // Apply the rules of one clock edge to the model.
  task automatic model_edge(input bit v, input logic [31:0] pc, input bit t,
                            input logic [31:0] tgt, input bit f);
    int         idx;
    logic [3:0] tg;
    idx = int'((pc >> 2) & 32'hFF);
    tg  = 4'((pc >> 10) & 32'hF);
    if (m_busy) begin
      m_sweep_cnt++;
      if (m_sweep_cnt == 256) begin
        m_busy = 1'b0;
        for (int i = 0; i < 256; i++) mdl[i].valid = 1'b0;
      end
    end else if (f) begin
      m_busy      = 1'b1;
      m_sweep_cnt = 0;
    end else if (v) begin
      if (mdl[idx].valid && mdl[idx].tag == tg) begin
        if (t) begin
          if (mdl[idx].ctr != 2'd3) mdl[idx].ctr = mdl[idx].ctr + 2'd1;
          mdl[idx].target = tgt;
        end else if (mdl[idx].ctr != 2'd0) begin
          mdl[idx].ctr = mdl[idx].ctr - 2'd1;
        end
      end else if (t) begin
        mdl[idx].valid  = 1'b1;
        mdl[idx].tag    = tg;
        mdl[idx].target = tgt;
        mdl[idx].ctr    = 2'd2;
      end
    end
  endtask

  // One clock: drive at posedge+1, check before the next edge, update model.
  task automatic step(input string tag, input logic [31:0] lpc, input bit v,
                      input logic [31:0] upc, input bit t, input logic [31:0] tgt,
                      input bit f);
    lkp_pc     = lpc;
    upd_valid  = v;
    upd_pc     = upc;
    upd_taken  = t;
    upd_target = tgt;
    flush      = f;
    #2;
    check_lookup(tag, lpc);
    @(posedge clk);
    model_edge(v, upc, t, tgt, f);
    #1;
  endtask

  // Lookup without a clock; checks model and explicit expected values.
  task automatic look(input string tag, input logic [31:0] lpc, input bit eh,
                      input bit et, input logic [31:0] etgt);
    lkp_pc    = lpc;
    upd_valid = 1'b0;
    flush     = 1'b0;
    #1;
    check_lookup(tag, lpc);
    chk({tag, ".hit_exp"},    {31'b0, lkp_hit},   {31'b0, eh});
    chk({tag, ".taken_exp"},  {31'b0, lkp_taken}, {31'b0, et});
    chk({tag, ".target_exp"}, lkp_target,         etgt);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] p;
    p = ($urandom & 32'hFFFF_C000) | ($urandom_range(0, 3) << 10) |
        ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
    return p;
  endfunction

  initial begin
    int bc;
    model_reset();
    rst_n      = 1'b0;
    lkp_pc     = 32'h100;
    upd_valid  = 1'b0;
    upd_pc     = 32'h0;
    upd_taken  = 1'b0;
    upd_target = 32'h0;
    flush      = 1'b0;
    #2;
    chk("rst.hit",    {31'b0, lkp_hit},   32'h0);
    chk("rst.taken",  {31'b0, lkp_taken}, 32'h0);
    chk("rst.target", lkp_target,         32'h0);
    chk("rst.busy",   {31'b0, busy},      32'h0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Lookup after reset misses.
    look("post_rst", 32'h100, 1'b0, 1'b0, 32'h0);

    // Taken miss allocates weakly taken.
    step("alloc", 32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0);
    look("alloc_lk", 32'h100, 1'b1, 1'b1, 32'h200);

    // Not-taken updates walk the counter down and saturate.
    for (int i = 0; i < 3; i++) step("nt", 32'h100, 1'b1, 32'h100, 1'b0, 32'h999, 1'b0);
    look("nt_lk", 32'h100, 1'b1, 1'b0, 32'h200);
    step("t1", 32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0);
    look("t1_lk", 32'h100, 1'b1, 1'b0, 32'h200);
    for (int i = 0; i < 3; i++) step("t", 32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0);
    look("t_lk", 32'h100, 1'b1, 1'b1, 32'h200);

    // Not-taken miss and upd_valid=0 leave the table alone.
    step("nt_miss", 32'h104, 1'b1, 32'h104, 1'b0, 32'h300, 1'b0);
    step("no_valid", 32'h108, 1'b0, 32'h108, 1'b1, 32'h300, 1'b0);
    look("nt_miss_lk", 32'h104, 1'b0, 1'b0, 32'h0);
    look("no_valid_lk", 32'h108, 1'b0, 1'b0, 32'h0);

    // Aliasing: same index, different tag replaces the entry.
    step("alias", 32'h100, 1'b1, 32'h500, 1'b1, 32'h700, 1'b0);
    look("alias_new", 32'h500, 1'b1, 1'b1, 32'h700);
    look("alias_old", 32'h100, 1'b0, 1'b0, 32'h0);

    // Same-cycle lookup and update: old contents now, new next cycle.
    step("bypass", 32'h500, 1'b1, 32'h500, 1'b0, 32'h0, 1'b0);
    look("bypass_next", 32'h500, 1'b1, 1'b0, 32'h700);

    // Flush with a simultaneous update: update dropped.
    step("pre_fl", 32'h100, 1'b1, 32'h100, 1'b1, 32'h240, 1'b0);
    step("flush", 32'h100, 1'b1, 32'h10C, 1'b1, 32'h444, 1'b1);
    bc = 0;
    for (int c = 0; c < 300; c++) begin
      if (busy) bc++;
      step("sweep", rand_pc(), 1'b1, rand_pc(), 1'($urandom), $urandom, c == 10);
    end
    chk("sweep_len", bc, 32'd256);
    look("post_sw_100", 32'h100, 1'b0, 1'b0, 32'h0);
    look("post_sw_500", 32'h500, 1'b0, 1'b0, 32'h0);
    look("post_sw_10c", 32'h10C, 1'b0, 1'b0, 32'h0);

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      step("rnd", rand_pc(), 1'($urandom_range(0, 3) != 0), rand_pc(),
           1'($urandom), $urandom, $urandom_range(0, 399) == 0);
    end
    while (m_busy) step("drain", rand_pc(), 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Reset in the middle of a sweep.
    step("pre_rst", 32'h100, 1'b1, 32'h100, 1'b1, 32'h280, 1'b0);
    look("pre_rst_lk", 32'h100, 1'b1, 1'b1, 32'h280);
    step("flush2", 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    for (int c = 0; c < 50; c++) step("sweep2", rand_pc(), 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    lkp_pc = 32'h100;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst.busy", {31'b0, busy},    32'h0);
    chk("midrst.hit",  {31'b0, lkp_hit}, 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    look("midrst_100", 32'h100, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 16; i++) look("midrst_rnd", rand_pc(), 1'b0, 1'b0, 32'h0);
    step("realloc", 32'h100, 1'b1, 32'h100, 1'b1, 32'h2C0, 1'b0);
    look("realloc_lk", 32'h100, 1'b1, 1'b1, 32'h2C0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
